tmr_scrub_ctrl: RTL and testbench

Scrub controller for a bank of triplicated (DTMR) state registers. It walks the register indices in order and reads all three replicas of each. Where the replicas disagree, it writes the majority-voted word back into the disagreeing replica(s), so that accumulated single-event upsets are cleared before a second upset can defeat the voters. It sits beside the DTMR datapath, owns the replica read/write side-port, and reports error statistics to the host.

---
 rtl/tmr_scrub_ctrl.sv | 110 +++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: scrubs triplicated registers by majority-voting each index and rewriting disagreeing replicas
// Ports: clk, rst_n (async active-low), start (scan request), clr_err (clear statistics),
//   rd_en/rd_addr -> replica read side-port, rd_data_0..2 <- replica words (one cycle after rd_en),
//   wr_en/wr_sel/wr_addr/wr_data -> correction write side-port,
//   busy/done -> scan status, err_count/err_flag/multi_err -> error statistics.
// Optional: define TMR_SCRUB_AUTO_EN to add an idle timer that starts a scan every SCRUB_PERIOD idle cycles.
module tmr_scrub_ctrl #(
  parameter int N_REGS       = 8,
  parameter int WIDTH        = 1,
  parameter int SCRUB_PERIOD = 256,
  localparam int IW          = $clog2(N_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_err,
  output logic             rd_en,
  output logic [IW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data_0,
  input  logic [WIDTH-1:0] rd_data_1,
  input  logic [WIDTH-1:0] rd_data_2,
  output logic             wr_en,
  output logic [2:0]       wr_sel,
  output logic [IW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic             err_flag,
  output logic             multi_err
);
  typedef enum logic [2:0] {IDLE, READ, CMP, WRITE, FIN} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] vote, vote_q;
  logic [2:0] mask, mask_q;
  logic all_diff, all_diff_q;
  logic last, trig, step;
  assign vote     = (rd_data_0 & rd_data_1) | (rd_data_0 & rd_data_2) | (rd_data_1 & rd_data_2);
  assign mask     = {rd_data_2 != vote, rd_data_1 != vote, rd_data_0 != vote};
  assign all_diff = (rd_data_0 != rd_data_1) && (rd_data_0 != rd_data_2) && (rd_data_1 != rd_data_2);
  assign last     = idx == IW'(N_REGS - 1);
  // advance to the next index after a clean compare or after a correction write
  assign step     = (state == CMP && mask == 3'b000) || state == WRITE;
`ifdef TMR_SCRUB_AUTO_EN
  localparam int TW = $clog2(SCRUB_PERIOD + 1);
  logic [TW-1:0] timer;
  // start and timer expiry in the same cycle collapse into one trigger
  assign trig = start || (timer == TW'(SCRUB_PERIOD - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else timer <= (state == IDLE && !trig) ? timer + 1'b1 : '0;
`else
  assign trig = start;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = trig ? READ : IDLE;
      READ:    next = CMP;
      CMP:     next = (mask != 3'b000) ? WRITE : (last ? FIN : READ);
      WRITE:   next = last ? FIN : READ;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx        <= '0;
      vote_q     <= '0;
      mask_q     <= '0;
      all_diff_q <= 1'b0;
    end else begin
      if (state == IDLE || state == FIN) idx <= '0;
      else if (step && !last) idx <= idx + 1'b1;
      if (state == CMP) begin
        vote_q     <= vote;
        mask_q     <= mask;
        all_diff_q <= all_diff;
      end
    end
  // clear takes priority over a coincident correction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_count <= '0;
      err_flag  <= 1'b0;
      multi_err <= 1'b0;
    end else if (clr_err) begin
      err_count <= '0;
      err_flag  <= 1'b0;
      multi_err <= 1'b0;
    end else if (state == WRITE) begin
      err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
      err_flag  <= 1'b1;
      multi_err <= multi_err | all_diff_q;
    end
  always_comb begin
    rd_en   = state == READ;
    rd_addr = idx;
    wr_en   = state == WRITE;
    wr_sel  = wr_en ? mask_q : 3'b000;
    wr_addr = idx;
    wr_data = wr_en ? vote_q : '0;
    busy    = state != IDLE;
    done    = state == FIN;
  end
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl: directed self-checking bench for tmr_scrub_ctrl (N_REGS=8, WIDTH=4, SCRUB_PERIOD=16)
module tb_tmr_scrub_ctrl;
  logic clk = 0, rst_n = 0, start = 0, clr_err = 0;
  logic rd_en, wr_en, busy, done, err_flag, multi_err;
  logic [2:0] rd_addr, wr_addr, wr_sel;
  logic [3:0] rd_data_0, rd_data_1, rd_data_2, wr_data;
  logic [15:0] err_count;
  logic [3:0] rep0 [8], rep1 [8], rep2 [8];
  int checks = 0, failures = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic rd_bad = 0;
  logic [2:0] last_addr = 0, last_sel = 0;
  logic [3:0] last_data = 0;
  int c;
  logic busy1, seen;

  tmr_scrub_ctrl #(.N_REGS(8), .WIDTH(4), .SCRUB_PERIOD(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_err(clr_err),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_count(err_count), .err_flag(err_flag), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) begin
      rd_data_0 <= rep0[rd_addr];
      rd_data_1 <= rep1[rd_addr];
      rd_data_2 <= rep2[rd_addr];
    end

  always @(posedge clk)
    if (start && !busy) begin
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      done_cnt <= 0;
      rd_bad   <= 0;
    end else begin
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_addr != 3'(rd_cnt)) rd_bad <= 1;
      end
      if (wr_en) begin
        wr_cnt    <= wr_cnt + 1;
        last_addr <= wr_addr;
        last_sel  <= wr_sel;
        last_data <= wr_data;
      end
      if (done) done_cnt <= done_cnt + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 8; i++) begin
      rep0[i] = v;
      rep1[i] = v;
      rep2[i] = v;
    end
  endtask

  task automatic run_scan(output int cyc, output logic b1);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    b1 = busy;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
  endtask

  initial begin
    fill(4'hA);
    #12;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_flags", {err_flag, multi_err}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    run_scan(c, busy1);
    chk("clean_done_cycle", c, 17);
    chk("clean_busy_first", busy1, 1);
    @(negedge clk);
    chk("clean_busy_after", busy, 0);
    chk("clean_rd_count", rd_cnt, 8);
    chk("clean_rd_order", rd_bad, 0);
    chk("clean_wr_count", wr_cnt, 0);
    chk("clean_err_count", err_count, 0);

    rep1[5] = 4'h2;
    run_scan(c, busy1);
    chk("single_done_cycle", c, 18);
    @(negedge clk);
    chk("single_wr_count", wr_cnt, 1);
    chk("single_wr_addr", last_addr, 5);
    chk("single_wr_sel", last_sel, 3'b010);
    chk("single_wr_data", last_data, 4'hA);
    chk("single_err_count", err_count, 1);
    chk("single_err_flag", err_flag, 1);
    chk("single_multi_err", multi_err, 0);

    rep1[5] = 4'hA;
    pulse_clr();
    chk("clr_err_count", err_count, 0);
    chk("clr_err_flag", err_flag, 0);
    rep0[3] = 4'h1;
    rep1[3] = 4'h2;
    rep2[3] = 4'h4;
    run_scan(c, busy1);
    @(negedge clk);
    chk("triple_wr_addr", last_addr, 3);
    chk("triple_wr_sel", last_sel, 3'b111);
    chk("triple_wr_data", last_data, 4'h0);
    chk("triple_multi_err", multi_err, 1);
    chk("triple_err_count", err_count, 1);

    fill(4'hA);
    pulse_clr();
    chk("clr_multi_err", multi_err, 0);
    force dut.err_count = 16'hFFFE;
    @(negedge clk);
    release dut.err_count;
    rep0[0] = 4'h5;
    rep0[2] = 4'h5;
    rep0[6] = 4'h5;
    run_scan(c, busy1);
    @(negedge clk);
    chk("sat_wr_count", wr_cnt, 3);
    chk("sat_err_count", err_count, 16'hFFFF);
    chk("sat_multi_err", multi_err, 0);

    rep0[0] = 4'hA;
    rep0[2] = 4'hA;
    start = 1;
    @(negedge clk);
    start = 0;
    c = 0;
    while (!wr_en && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("clrwr_seen_write", wr_en, 1);
    pulse_clr();
    c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk("clrwr_wr_count", wr_cnt, 1);
    chk("clrwr_err_count", err_count, 0);
    chk("clrwr_err_flag", err_flag, 0);

    fill(4'hA);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);
    chk("restart_done_count", done_cnt, 1);
    chk("restart_rd_count", rd_cnt, 8);
    chk("restart_rd_order", rd_bad, 0);
    chk("restart_busy", busy, 0);

    rep2[2] = 4'h3;
    start = 1;
    @(negedge clk);
    start = 0;
    c = 0;
    while (!wr_en && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("abort_seen_write", wr_en, 1);
    rst_n = 0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_wr_sel", wr_sel, 0);
    chk("abort_wr_data", wr_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1;

    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
`ifdef TMR_SCRUB_AUTO_EN
    chk("auto_scan_started", seen, 1);
`else
    chk("no_auto_scan", seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
